mux2_rr_arbiter_64: RTL
=======================

Name: mux2_rr_arbiter_64

Overview:
- Round-robin arbiter that shares one 64-bit datapath between two packet-oriented requesters (A, B).
- Drives the select of a 64-bit 2:1 data mux and registers the winning beat into a single output stage with valid/ready handshake.
- Grants are packet-locked: once a requester wins, it keeps the path until its beat marked last is accepted.
- Sits between two producers (e.g. two memory/ALU result sources) and a single downstream consumer.

Parameters:
- DW, 64, data width; must match the mux cell width.
- CW, 16, width of per-source completed-packet counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_valid  in  1  requester A beat valid.
- a_data  in  DW  requester A beat data.
- a_last  in  1  requester A beat ends its packet.
- a_ready  out  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid, b_data, b_last, b_ready: same as A, for requester B.
- o_valid  out  1  output beat valid (registered).
- o_data  out  DW  output beat data (registered).
- o_last  out  1  output beat is last of packet (registered).
- o_src  out  1  0 = beat came from A, 1 = from B (registered).
- o_ready  in  1  downstream accepts output beat.
- sel  out  1  current mux select; 1 = A, 0 = B (combinational).
- cnt_a  out  CW  packets completed from A (registered, wraps).
- cnt_b  out  CW  packets completed from B (registered, wraps).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, prio=A, o_valid=0, o_data=0, o_last=0, o_src=0, cnt_a=0, cnt_b=0. Reset mid-packet discards the partial packet; no beat is retained.
- space = !o_valid || o_ready. Output register loads iff space && granted requester valid.
- FSM states IDLE, LOCK_A, LOCK_B.
- IDLE grant (combinational):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one selected by prio.
  - If neither is valid, grant = prio; no ready is asserted.
- LOCK_A / LOCK_B: grant is fixed to A / B; the other requester's ready is 0 regardless of its valid.
- x_ready = (grant==x) && space. The non-granted ready is always 0. Ready may depend combinationally on the valids (in IDLE only).
- sel = 1 when grant==A, else 0; drives the mux. o_src = !sel at load.
- Transitions on an accepted beat from x:
  - last=0 in IDLE goes to LOCK_x.
  - last=1 in any state goes to IDLE, sets prio to the other source, and increments cnt_x (wraps at 2^CW-1 to 0).
  - No accepted beat leaves state and prio unchanged.
- Latency: a beat accepted at edge N appears on o_* after edge N, i.e. 1 cycle.
- Throughput is 1 beat/cycle when o_ready=1, including back-to-back packets from alternating sources (no idle bubble).
- Backpressure: while o_valid && !o_ready, o_data, o_last and o_src stay stable, and a_ready = b_ready = 0.
- An output beat leaving and a new beat loading on the same edge is legal and required.
- A valid dropped mid-packet by the locked requester: the FSM stays locked, no beats are taken, and the other requester stays blocked.

Decomposition:
- Shared package or header holds the state encodings (IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2), the SRC_A=1'b0 / SRC_B=1'b1 constants, and DW.
- Instantiate the team's existing 64-bit 2:1 mux cell MUX2T1_64 (sel=1 selects the first input, A) as the only sub-module. FSM, handshake and counters are inline.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with a_valid=b_valid=1 -> o_valid=0, a_ready=b_ready=0, cnt_a=cnt_b=0. First cycle after release: a_ready=1, b_ready=0, sel=1.
- Contention alternation: both always valid, single-beat packets (last=1), a_data=0xAAAA_0000_0000_000k, b_data=0xBBBB..., o_ready=1 -> o_src sequence 0,1,0,1 on consecutive cycles. After 4 beats cnt_a=2, cnt_b=2.
- Packet lock: A sends a 3-beat packet (last on beat 3) while B is valid throughout -> b_ready=0 for all 3 beats. B's first beat appears on the cycle after A's last. cnt_a increments exactly once.
- Backpressure: o_ready=0 for 3 cycles with o_valid=1, data 0x0123_4567_89AB_CDEF -> o_data is stable and a_ready=b_ready=0. Asserting o_ready=1 gives a load on the same edge, with no lost or duplicated beat.
- Reset mid-packet: A accepts 2 of 4 beats, then rst_n=0 for 1 cycle -> state=IDLE, o_valid=0, cnt_a=0. B (valid, prio=A but A idle) is granted the next cycle.
- Counter wrap: CW=4, complete 17 single-beat A packets -> cnt_a reads 1 after the 17th and cnt_b stays 0.

Source files
------------

// File: rtl/mux2_rr_arbiter_64_pkg.sv
// mux2_rr_arbiter_64_pkg: state encodings, source ids and data width shared by the arbiter
package mux2_rr_arbiter_64_pkg;
  localparam int DW = 64;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_A = 2'd1;
  localparam logic [1:0] LOCK_B = 2'd2;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/mux2_rr_arbiter_64_mux.sv
// MUX2T1_64: 64-bit 2:1 mux cell
// ports: a_i/b_i data inputs, sel_i (1 selects a_i), y_o selected data
module MUX2T1_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        sel_i,
  output logic [63:0] y_o
);
  assign y_o = sel_i ? a_i : b_i;
endmodule

// File: rtl/mux2_rr_arbiter_64.sv
// mux2_rr_arbiter_64: packet-locked round-robin arbiter sharing one registered 64-bit path between A and B
// ports: clk/rst_n (sync, active-low); a_*/b_* requester beats with valid/ready/last;
//        o_* registered output beat with source id; sel mux select (1 = A); cnt_a/cnt_b completed packets
module mux2_rr_arbiter_64 #(
  parameter int DW = mux2_rr_arbiter_64_pkg::DW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic          b_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          o_src,
  input  logic          o_ready,
  output logic          sel,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);
  import mux2_rr_arbiter_64_pkg::*;
  logic [1:0] state_q, state_d;
  logic prio_q, prio_d;
  logic o_valid_q, o_last_q, o_src_q;
  logic [DW-1:0] o_data_q;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic space, grant, idle, take, last_m, done;
  logic [DW-1:0] mux_y;
  assign idle = state_q == IDLE;
  assign space = !o_valid_q || o_ready;
  assign grant = state_q == LOCK_A ? SRC_A : state_q == LOCK_B ? SRC_B :
                 (a_valid && b_valid) ? prio_q : a_valid ? SRC_A : b_valid ? SRC_B : prio_q;
  assign sel = grant == SRC_A;
  // in IDLE ready follows the requester's valid so an idle prio source is never offered a slot
  assign a_ready = rst_n && space && sel && (!idle || a_valid);
  assign b_ready = rst_n && space && !sel && (!idle || b_valid);
  assign take = sel ? a_valid && a_ready : b_valid && b_ready;
  assign last_m = sel ? a_last : b_last;
  assign done = take && last_m;
  MUX2T1_64 u_mux (.a_i(a_data), .b_i(b_data), .sel_i(sel), .y_o(mux_y));
  always_comb begin
    state_d = !take ? state_q : last_m ? IDLE : sel ? LOCK_A : LOCK_B;
    prio_d = done ? ~grant : prio_q;
    cnt_a_d = cnt_a_q + CW'(done && sel);
    cnt_b_d = cnt_b_q + CW'(done && !sel);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q <= SRC_A;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      o_last_q <= 1'b0;
      o_src_q <= SRC_A;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      o_valid_q <= take || (o_valid_q && !o_ready);
      if (take) begin
        o_data_q <= mux_y;
        o_last_q <= last_m;
        o_src_q <= grant;
      end
    end
  end
  assign o_valid = o_valid_q;
  assign o_data = o_data_q;
  assign o_last = o_last_q;
  assign o_src = o_src_q;
  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
endmodule
